// File: rtl/limit_pressure_pkg.sv
// Shared definitions for the chamber pressure-limit key bank.
//   limit_state_t : per-channel limit flag state (WITHIN / BEYOND)
//   MODE_*        : per-channel mode encodings on the mode input
package limit_pressure_pkg;

  typedef enum logic {
    WITHIN = 1'b0,
    BEYOND = 1'b1
  } limit_state_t;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  // Next limit state for one channel, given the current state and inputs.
  function automatic limit_state_t limit_next(
    input limit_state_t cur,
    input logic         mode_bit,
    input logic         lock_bit,
    input logic         deb_bit,
    input logic         rise_bit
  );
    limit_state_t nxt;
    nxt = cur;
    if (!lock_bit) begin
      if (mode_bit == MODE_MOMENTARY) begin
        nxt = deb_bit ? BEYOND : WITHIN;
      end else if (rise_bit) begin
        nxt = (cur == BEYOND) ? WITHIN : BEYOND;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser and debouncer for one raw operator key.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   key   : raw key, asynchronous to clk, active-high
//   deb   : debounced key level
//   rise  : single-cycle press event (deb rising), combinational from deb/deb_d
module key_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic deb,
  output logic rise
);
  import limit_pressure_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // The counter only runs while s2 disagrees with deb and is cleared on
  // agreement, so a glitch shorter than DEBOUNCE cycles never reaches deb
  // and cnt never passes CNT_LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = deb & ~deb_d;

endmodule

// File: rtl/limit_pressure_bank.sv
// Multi-channel WITHIN/BEYOND pressure-limit flag bank.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   key        : raw operator keys (NUM_CH), asynchronous, active-high
//   mode       : per-channel mode, 0 = TOGGLE, 1 = MOMENTARY
//   lock       : 1 = hold every flag and discard key events
//   limit      : per-channel flag, 0 = WITHIN, 1 = BEYOND
//   changed    : one-cycle pulse in the cycle limit[i] shows a new value
//   any_beyond : OR of limit, registered alongside limit
module limit_pressure_bank #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] key,
  input  logic [NUM_CH-1:0] mode,
  input  logic              lock,
  output logic [NUM_CH-1:0] limit,
  output logic [NUM_CH-1:0] changed,
  output logic              any_beyond
);
  import limit_pressure_pkg::*;

  logic [NUM_CH-1:0] next_limit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic         deb;
    logic         rise;
    limit_state_t state_q;
    limit_state_t state_d;

    key_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .key  (key[i]),
      .deb  (deb),
      .rise (rise)
    );

    // A rise arriving under lock is simply not applied; it is not queued.
    always_comb begin
      state_d = state_q;
      state_d = limit_next(state_q, mode[i], lock, deb, rise);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q    <= WITHIN;
        changed[i] <= 1'b0;
      end else begin
        state_q    <= state_d;
        changed[i] <= (state_d != state_q);
      end
    end

    assign limit[i]      = (state_q == BEYOND);
    assign next_limit[i] = (state_d == BEYOND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_beyond <= 1'b0;
    end else begin
      any_beyond <= |next_limit;
    end
  end

endmodule

// File: tb/tb_limit_pressure_bank.sv
module tb_limit_pressure_bank;
  import limit_pressure_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] key;
  logic [1:0] mode;
  logic       lock;
  logic [1:0] limit;
  logic [1:0] changed;
  logic       any_beyond;

  int unsigned checks;
  int unsigned failures;
  logic [1:0]  saw_changed;

  limit_pressure_bank #(
    .NUM_CH  (2),
    .DEBOUNCE(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .mode      (mode),
    .lock      (lock),
    .limit     (limit),
    .changed   (changed),
    .any_beyond(any_beyond)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    key   = 2'b00;
    mode  = 2'b00;
    lock  = 1'b0;
    step(3);
    check("rst_limit", 8'(limit), 8'h0);
    check("rst_changed", 8'(changed), 8'h0);
    check("rst_any", 8'(any_beyond), 8'h0);
    reset = 1'b1;
    step(2);

    // Short glitch on ch0 (3 cycles) must be rejected.
    key = 2'b01;
    step(3);
    key = 2'b00;
    saw_changed = 2'b00;
    for (int unsigned k = 0; k < 10; k++) begin
      step(1);
      saw_changed |= changed;
    end
    check("glitch_limit", 8'(limit), 8'h0);
    check("glitch_changed", 8'(saw_changed), 8'h0);

    // TOGGLE press of 10 cycles: flip at t0+6, exactly once.
    key = 2'b01;
    step(6);
    check("tog_pre", 8'(limit), 8'h0);
    step(1);
    check("tog_limit", 8'(limit), 8'h1);
    check("tog_changed", 8'(changed), 8'h1);
    check("tog_any", 8'(any_beyond), 8'h1);
    step(1);
    check("tog_pulse_end", 8'(changed), 8'h0);
    step(2);
    key = 2'b00;
    saw_changed = 2'b00;
    for (int unsigned k = 0; k < 10; k++) begin
      step(1);
      saw_changed |= changed;
    end
    check("tog_hold", 8'(limit), 8'h1);
    check("tog_noflip", 8'(saw_changed), 8'h0);

    // Second TOGGLE press returns ch0 to WITHIN.
    key = 2'b01;
    step(6);
    check("tog2_pre", 8'(limit), 8'h1);
    step(1);
    check("tog2_limit", 8'(limit), 8'h0);
    check("tog2_changed", 8'(changed), 8'h1);
    check("tog2_any", 8'(any_beyond), 8'h0);
    step(3);
    key = 2'b00;
    step(8);

    // MOMENTARY ch1 follows the debounced key.
    mode = 2'b10;
    key = 2'b10;
    step(6);
    check("mom_pre", 8'(limit), 8'h0);
    check("mom_pre_any", 8'(any_beyond), 8'h0);
    step(1);
    check("mom_limit", 8'(limit), 8'h2);
    check("mom_changed", 8'(changed), 8'h2);
    check("mom_any", 8'(any_beyond), 8'h1);
    step(1);
    key = 2'b00;
    check("mom_pulse_end", 8'(changed), 8'h0);
    step(6);
    check("mom_rel_pre", 8'(limit), 8'h2);
    check("mom_rel_pre_any", 8'(any_beyond), 8'h1);
    step(1);
    check("mom_rel", 8'(limit), 8'h0);
    check("mom_rel_changed", 8'(changed), 8'h2);
    check("mom_rel_any", 8'(any_beyond), 8'h0);
    step(3);

    // Locked TOGGLE press is discarded and not replayed after unlock.
    mode = 2'b00;
    lock = 1'b1;
    key  = 2'b01;
    saw_changed = 2'b00;
    for (int unsigned k = 0; k < 18; k++) begin
      if (k == 10) key = 2'b00;
      step(1);
      saw_changed |= changed;
    end
    check("lock_tog_limit", 8'(limit), 8'h0);
    check("lock_tog_changed", 8'(saw_changed), 8'h0);
    lock = 1'b0;
    step(4);
    check("lock_tog_lost", 8'(limit), 8'h0);

    // Locked MOMENTARY resynchronises to deb on the first unlocked edge.
    mode = 2'b01;
    lock = 1'b1;
    key  = 2'b01;
    step(10);
    check("lock_mom_hold", 8'(limit), 8'h0);
    check("lock_mom_nochg", 8'(changed), 8'h0);
    lock = 1'b0;
    step(1);
    check("lock_mom_resync", 8'(limit), 8'h1);
    check("lock_mom_changed", 8'(changed), 8'h1);
    key = 2'b00;
    step(7);
    check("lock_mom_rel", 8'(limit), 8'h0);
    step(2);

    // Simultaneous press: ch0 TOGGLE, ch1 MOMENTARY.
    mode = 2'b10;
    key  = 2'b11;
    step(6);
    check("both_pre", 8'(limit), 8'h0);
    step(1);
    check("both_limit", 8'(limit), 8'h3);
    check("both_changed", 8'(changed), 8'h3);
    check("both_any", 8'(any_beyond), 8'h1);
    step(1);
    check("both_pulse_end", 8'(changed), 8'h0);
    step(3);

    // Asynchronous reset mid-run clears outputs before the next edge.
    #5 reset = 1'b0;
    #2;
    check("arst_limit", 8'(limit), 8'h0);
    check("arst_changed", 8'(changed), 8'h0);
    check("arst_any", 8'(any_beyond), 8'h0);
    @(negedge clk);
    reset = 1'b1;

    // Keys still held after reset release look like a fresh press.
    step(6);
    check("post_rst_pre", 8'(limit), 8'h0);
    step(1);
    check("post_rst_limit", 8'(limit), 8'h3);
    check("post_rst_changed", 8'(changed), 8'h3);
    key = 2'b00;
    step(8);
    check("post_rst_rel", 8'(limit), 8'h1);
    check("post_rst_any", 8'(any_beyond), 8'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
